// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - address map and status bit layout for the IO bus unit
package io_bus_pkg;

    localparam logic [7:0] IO_LED      = 8'h00;
    localparam logic [7:0] IO_IN_STAT  = 8'h04;
    localparam logic [7:0] IO_IN_DATA  = 8'h08;
    localparam logic [7:0] IO_OUT_STAT = 8'h0C;
    localparam logic [7:0] IO_OUT_DATA = 8'h10;
    localparam logic [7:0] IO_CYCLE    = 8'h14;

    localparam int ST_VLD = 0;
    localparam int ST_ERR = 1;

    // Registers are word-aligned; the byte-offset bits never select anything.
    function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] reg_addr);
        return addr[7:2] == reg_addr[7:2];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a stable-level debounce counter
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // The counter only runs while a new level is pending; any return to the
    // current debounced level restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            dout   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync_2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_bus_unit.sv
// rtl/io_bus_unit.sv - memory-mapped LED, display and button/switch peripheral with cycle counter
module io_bus_unit
    import io_bus_pkg::*;
#(
    parameter int DB_CYCLES   = 1000000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    output logic [31:0] io_din,
    input  logic        btn,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [31:0] seg_data,
    output logic        seg_busy
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic          btn_db;
    logic          btn_db_q;
    logic          btn_rise;
    logic [15:0]   in_data;
    logic          in_vld;
    logic          in_ovr;
    logic          out_rdy;
    logic          out_drop;
    logic [HW-1:0] hold_cnt;
    logic [31:0]   cyc;

    logic wr_led;
    logic wr_in_ack;
    logic wr_out_stat;
    logic wr_out_data;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn),
        .dout (btn_db)
    );

    assign btn_rise    = btn_db & ~btn_db_q;
    assign wr_led      = io_we & addr_hit(io_addr, IO_LED);
    assign wr_in_ack   = io_we & addr_hit(io_addr, IO_IN_STAT);
    assign wr_out_stat = io_we & addr_hit(io_addr, IO_OUT_STAT);
    assign wr_out_data = io_we & addr_hit(io_addr, IO_OUT_DATA);
    assign seg_busy    = ~out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            btn_db_q <= 1'b0;
            in_data  <= '0;
            in_vld   <= 1'b0;
            in_ovr   <= 1'b0;
            cyc      <= '0;
        end else begin
            cyc      <= cyc + 32'd1;
            btn_db_q <= btn_db;
            if (wr_led) begin
                led <= io_dout[15:0];
            end
            // A new press beats a coincident acknowledge so no sample is lost.
            if (btn_rise && (wr_in_ack || !in_vld)) begin
                in_data <= sw;
                in_vld  <= 1'b1;
                in_ovr  <= 1'b0;
            end else if (btn_rise) begin
                in_ovr <= 1'b1;
            end else if (wr_in_ack) begin
                in_vld <= 1'b0;
                in_ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data <= '0;
            out_rdy  <= 1'b1;
            out_drop <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end else if (!out_rdy) begin
                out_rdy <= 1'b1;
            end
            if (wr_out_data && out_rdy) begin
                seg_data <= io_dout;
                out_rdy  <= 1'b0;
                hold_cnt <= HOLD_LOAD;
            end
            // Clearing and a fresh drop in the same cycle keep the drop visible.
            if (wr_out_data && !out_rdy) begin
                out_drop <= 1'b1;
            end else if (wr_out_stat) begin
                out_drop <= 1'b0;
            end
        end
    end

    always_comb begin
        io_din = '0;
        if (addr_hit(io_addr, IO_LED)) begin
            io_din = {16'h0, led};
        end else if (addr_hit(io_addr, IO_IN_STAT)) begin
            io_din[ST_VLD] = in_vld;
            io_din[ST_ERR] = in_ovr;
        end else if (addr_hit(io_addr, IO_IN_DATA)) begin
            io_din = {16'h0, in_data};
        end else if (addr_hit(io_addr, IO_OUT_STAT)) begin
            io_din[ST_VLD] = out_rdy;
            io_din[ST_ERR] = out_drop;
        end else if (addr_hit(io_addr, IO_OUT_DATA)) begin
            io_din = seg_data;
        end else if (addr_hit(io_addr, IO_CYCLE)) begin
            io_din = cyc;
        end
    end

endmodule

// File: tb/tb_io_bus_unit.sv
// tb/tb_io_bus_unit.sv - directed self-checking bench for io_bus_unit
module tb_io_bus_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;
    logic        btn;
    logic [15:0] sw;
    logic [15:0] led;
    logic [31:0] seg_data;
    logic        seg_busy;

    int n_checks = 0;
    int n_fail   = 0;

    io_bus_unit #(.DB_CYCLES(4), .HOLD_CYCLES(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_we    (io_we),
        .io_din   (io_din),
        .btn      (btn),
        .sw       (sw),
        .led      (led),
        .seg_data (seg_data),
        .seg_busy (seg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr = a;
        io_dout = d;
        io_we   = 1'b1;
        @(posedge clk);
        #1;
        io_we   = 1'b0;
        io_addr = 8'h3C;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        io_addr = a;
        #1;
        d = io_din;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h exp %h", led, 16'h0); end
        n_checks++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL reset_seg_data: got %h exp %h", seg_data, 32'h0); end
        n_checks++; if (seg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_seg_busy: got %b exp 0", seg_busy); end
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL reset_out_stat: got %h exp %h", v, 32'h1); end
        rd(8'h04, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_in_stat: got %h exp %h", v, 32'h0); end
        rst = 1'b0;
        rd(8'h14, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_cyc0: got %h exp %h", v, 32'd0); end
        tick(1);
        rd(8'h14, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL reset_cyc1: got %h exp %h", v, 32'd1); end
        tick(1);
        rd(8'h14, v);
        n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL reset_cyc2: got %h exp %h", v, 32'd2); end
    endtask

    task automatic test_led;
        logic [31:0] v;
        wr(8'h00, 32'hABCD1234);
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL led_write: got %h exp %h", led, 16'h1234); end
        rd(8'h00, v);
        n_checks++; if (v !== 32'h00001234) begin n_fail++; $display("FAIL led_read: got %h exp %h", v, 32'h00001234); end
        rd(8'h03, v);
        n_checks++; if (v !== 32'h00001234) begin n_fail++; $display("FAIL led_read_byte_offset: got %h exp %h", v, 32'h00001234); end
        wr(8'h20, 32'hFFFFFFFF);
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL unmapped_led: got %h exp %h", led, 16'h1234); end
        n_checks++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_seg: got %h exp %h", seg_data, 32'h0); end
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL unmapped_out_stat: got %h exp %h", v, 32'h1); end
        rd(8'h20, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_input;
        logic [31:0] v;
        sw  = 16'h5A5A;
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(10);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL glitch_ignored: got %h exp %h", v, 32'h0); end
        btn = 1'b1;
        tick(6);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h exp %h", v, 32'h0); end
        tick(1);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL press_vld: got %h exp %h", v, 32'h1); end
        rd(8'h08, v);
        n_checks++; if (v !== 32'h00005A5A) begin n_fail++; $display("FAIL press_data: got %h exp %h", v, 32'h00005A5A); end
        btn = 1'b0;
        tick(10);
        sw  = 16'h1111;
        btn = 1'b1;
        tick(10);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h3) begin n_fail++; $display("FAIL overrun_stat: got %h exp %h", v, 32'h3); end
        rd(8'h08, v);
        n_checks++; if (v !== 32'h00005A5A) begin n_fail++; $display("FAIL overrun_data: got %h exp %h", v, 32'h00005A5A); end
        wr(8'h04, 32'h0);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL ack_clears: got %h exp %h", v, 32'h0); end
        btn = 1'b0;
        tick(10);
    endtask

    task automatic test_edge_ack;
        logic [31:0] v;
        sw  = 16'h3333;
        btn = 1'b1;
        tick(10);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL edge_ack_pre: got %h exp %h", v, 32'h1); end
        btn = 1'b0;
        tick(10);
        sw  = 16'h0F0F;
        btn = 1'b1;
        tick(6);
        wr(8'h04, 32'h0);
        rd(8'h04, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL edge_ack_stat: got %h exp %h", v, 32'h1); end
        rd(8'h08, v);
        n_checks++; if (v !== 32'h00000F0F) begin n_fail++; $display("FAIL edge_ack_data: got %h exp %h", v, 32'h00000F0F); end
        btn = 1'b0;
        tick(10);
    endtask

    task automatic test_output;
        logic [31:0] v;
        wr(8'h10, 32'hDEADBEEF);
        wr(8'h10, 32'h00000001);
        n_checks++; if (seg_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL out_seg_data: got %h exp %h", seg_data, 32'hDEADBEEF); end
        rd(8'h10, v);
        n_checks++; if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL out_read_data: got %h exp %h", v, 32'hDEADBEEF); end
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h2) begin n_fail++; $display("FAIL out_stat_hold: got %h exp %h", v, 32'h2); end
        tick(3);
        n_checks++; if (seg_busy !== 1'b1) begin n_fail++; $display("FAIL out_busy_cycle5: got %b exp 1", seg_busy); end
        tick(1);
        n_checks++; if (seg_busy !== 1'b0) begin n_fail++; $display("FAIL out_rdy_return: got %b exp 0", seg_busy); end
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h3) begin n_fail++; $display("FAIL out_stat_after: got %h exp %h", v, 32'h3); end
        wr(8'h0C, 32'h0);
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL out_drop_clear: got %h exp %h", v, 32'h1); end
    endtask

    task automatic test_reset_mid_hold;
        logic [31:0] v;
        wr(8'h10, 32'h12345678);
        n_checks++; if (seg_data !== 32'h12345678) begin n_fail++; $display("FAIL hold2_seg: got %h exp %h", seg_data, 32'h12345678); end
        n_checks++; if (seg_busy !== 1'b1) begin n_fail++; $display("FAIL hold2_busy: got %b exp 1", seg_busy); end
        tick(2);
        rst = 1'b1;
        #1;
        n_checks++; if (seg_busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b exp 0", seg_busy); end
        n_checks++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL async_rst_seg: got %h exp %h", seg_data, 32'h0); end
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL async_rst_led: got %h exp %h", led, 16'h0); end
        tick(2);
        rst = 1'b0;
        rd(8'h0C, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL post_rst_out_stat: got %h exp %h", v, 32'h1); end
        tick(6);
        n_checks++; if (seg_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b exp 0", seg_busy); end
        rd(8'h10, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL post_rst_seg: got %h exp %h", v, 32'h0); end
    endtask

    initial begin
        rst     = 1'b1;
        io_addr = 8'h3C;
        io_dout = 32'h0;
        io_we   = 1'b0;
        btn     = 1'b0;
        sw      = 16'h0;
        test_reset;
        test_led;
        test_input;
        test_edge_ack;
        test_output;
        test_reset_mid_hold;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
